// File: rtl/microuaz_pkg.sv
// Shared types and constants for the MicroUAZ datapath.
// Holds the left-shifter FSM state type and the default operand width.
package microuaz_pkg;

  localparam int MICROUAZ_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } despl_state_t;

endpackage

// File: rtl/desplazamiento_contador.sv
// Loadable W-bit down-counter for the multi-cycle left shifter.
// Flags last while the count equals one, so the shift ends after this edge.
module desplazamiento_contador #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/desplazamiento_izquierda_seq.sv
// Multi-cycle logical left shifter: one bit per clock, with carry and zero flags.
// Define DESPL_IZQ_ROT_EN to add the rot input and rotate-left mode.
module desplazamiento_izquierda_seq
  import microuaz_pkg::*;
#(
  parameter int N = MICROUAZ_N,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [W-1:0] amt,
`ifdef DESPL_IZQ_ROT_EN
  input  logic         rot,
`endif
  output logic [N-1:0] Y,
  output logic         C,
  output logic         Z,
  output logic         busy,
  output logic         done
);

  despl_state_t state;
  logic [N-1:0] y_nxt;
  logic         fill;
  logic         accept;
  logic         last;

  assign accept = (state == ST_IDLE) && start;

`ifdef DESPL_IZQ_ROT_EN
  logic rot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= rot;
    end
  end

  assign fill = rot_q ? Y[N-1] : 1'b0;
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    y_nxt = {Y[N-2:0], fill};
  end

  desplazamiento_contador #(
    .W(W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (state == ST_SHIFT),
    .din  (amt),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      Y     <= '0;
      C     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            Y     <= A;
            C     <= 1'b0;
            Z     <= (A == '0);
            state <= (amt != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          Y <= y_nxt;
          C <= Y[N-1];
          Z <= (y_nxt == '0);
          if (last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_desplazamiento_izquierda_seq.sv
// Directed bench for desplazamiento_izquierda_seq (N=8).
// Rotate vectors run only when DESPL_IZQ_ROT_EN is defined.
module tb_desplazamiento_izquierda_seq;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [W-1:0] amt;
  logic         rot;
  logic [N-1:0] Y;
  logic         C;
  logic         Z;
  logic         busy;
  logic         done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  desplazamiento_izquierda_seq #(
    .N(N)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .amt   (amt),
`ifdef DESPL_IZQ_ROT_EN
    .rot   (rot),
`endif
    .Y     (Y),
    .C     (C),
    .Z     (Z),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [W-1:0] amt;
    logic         rot;
    logic [N-1:0] y;
    logic         c;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start at a negedge, follow until done, check flags and the idle cycle after.
  task automatic run_op(input vec_t v, input string name);
    int got;
    A     = v.a;
    amt   = v.amt;
    rot   = v.rot;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    got = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got = i;
        break;
      end
      chk({name, " busy_run"}, int'(busy), 1);
      @(negedge clk);
    end
    chk({name, " latency"}, got, int'(v.amt));
    chk({name, " busy_done"}, int'(busy), 1);
    chk({name, " Y"}, int'(Y), int'(v.y));
    chk({name, " C"}, int'(C), int'(v.c));
    chk({name, " Z"}, int'(Z), int'(v.z));
    @(negedge clk);
    chk({name, " done_pulse"}, int'(done), 0);
    chk({name, " busy_idle"}, int'(busy), 0);
    chk({name, " Y_hold"}, int'(Y), int'(v.y));
    chk({name, " C_hold"}, int'(C), int'(v.c));
  endtask

  vec_t vecs[8];
  vec_t v;
  int   pulses;

  initial begin
    vecs[0] = '{8'h96, 3'd3, 1'b0, 8'hB0, 1'b0, 1'b0};
    vecs[1] = '{8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'hFF, 3'd7, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 3'd7, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{8'h40, 3'd2, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'hC3, 3'd4, 1'b0, 8'h30, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    amt   = '0;
    rot   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset Y", int'(Y), 0);
    chk("reset C", int'(C), 0);
    chk("reset Z", int'(Z), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Second start during SHIFT must be ignored.
    A     = 8'hFF;
    amt   = 3'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        A     = 8'h00;
        amt   = 3'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        chk("ignore latency", i, 7);
        chk("ignore Y", int'(Y), 8'h80);
        chk("ignore C", int'(C), 1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore pulses", pulses, 1);

    // Reset in the middle of a shift aborts it.
    A     = 8'h0F;
    amt   = 3'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort busy_pre", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", int'(busy), 0);
    chk("abort Y", int'(Y), 0);
    chk("abort C", int'(C), 0);
    chk("abort Z", int'(Z), 0);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("abort no_done", pulses, 0);

`ifdef DESPL_IZQ_ROT_EN
    v = '{8'h81, 3'd1, 1'b1, 8'h03, 1'b1, 1'b0};
    run_op(v, "rot1");
    v = '{8'h81, 3'd1, 1'b0, 8'h02, 1'b1, 1'b0};
    run_op(v, "rot0");
    v = '{8'hC3, 3'd4, 1'b1, 8'h3C, 1'b0, 1'b0};
    run_op(v, "rot4");
`else
    v = '{8'h81, 3'd1, 1'b0, 8'h02, 1'b1, 1'b0};
    run_op(v, "lsl81");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
